// File: rtl/ili9341_pkg.sv
// ILI9341 SPI write path: shared state type and constants.
// Optional macro ILI9341_SPI_CS_HOLD_EN is used by ili9341_spi_tx.
package ili9341_pkg;
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } spi_state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;
  localparam int SPI_DATA_WIDTH = 8;
endpackage

// File: rtl/ili9341_spi_tx_tick.sv
// SCK half-period tick generator.
// Pulses every SCK_HALF cycles while enabled, clears when disabled.
module spi_sck_tick
  import ili9341_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic i_clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = $clog2(SCK_HALF + 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  assign w_tick = i_en && (r_cnt == CW'(SCK_HALF - 1));
  assign o_tick = w_tick;

  always_ff @(posedge i_clk) begin
    if (rst || !i_en || w_tick)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/ili9341_spi_tx.sv
// ILI9341 byte serializer, SPI mode 0, MSB first, write-only.
// Define ILI9341_SPI_CS_HOLD_EN to chain bytes without a CS gap.
module ili9341_spi_tx
  import ili9341_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int SCK_HALF   = 2
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_dc,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_sck,
  output logic                  o_mosi,
  output logic                  o_cs_n,
  output logic                  o_dc,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int EW = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);

  spi_state_t            r_state;
  spi_state_t            w_next;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [EW-1:0]         r_edge;
  logic                  r_sck;
  logic                  r_mosi;
  logic                  r_cs_n;
  logic                  r_dc;
  logic                  r_done;
  logic                  w_en;
  logic                  w_tick;
  logic                  w_hold_end;
  logic                  w_last_fall;
  logic                  w_ready;
  logic                  w_accept;

  assign w_en = (r_state != IDLE);

  spi_sck_tick #(
    .SCK_HALF(SCK_HALF)
  ) u_tick (
    .i_clk (i_clk),
    .rst   (rst),
    .i_en  (w_en),
    .o_tick(w_tick)
  );

  assign w_hold_end  = (r_state == HOLD) && w_tick;
  assign w_last_fall = (r_state == SHIFT) && w_tick && r_sck
                       && (r_edge == LAST_EDGE - 1'b1);

`ifdef ILI9341_SPI_CS_HOLD_EN
  assign w_ready = ((r_state == IDLE) || w_hold_end) && !rst;
`else
  assign w_ready = (r_state == IDLE) && !rst;
`endif

  assign w_accept = i_valid && w_ready;

  always_ff @(posedge i_clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = SHIFT;
      SHIFT:   if (w_last_fall) w_next = HOLD;
      HOLD:    if (w_hold_end) w_next = w_accept ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A chained accept in the last HOLD cycle overrides the CS release.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_shift <= '0;
      r_edge  <= '0;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_hold_end;
      if (w_hold_end)
        r_cs_n <= 1'b1;
      if (w_accept) begin
        r_shift <= i_data;
        r_dc    <= i_dc;
        r_mosi  <= i_data[DATA_WIDTH-1];
        r_cs_n  <= 1'b0;
        r_sck   <= 1'b0;
        r_edge  <= '0;
      end else if ((r_state == SHIFT) && w_tick) begin
        r_sck  <= ~r_sck;
        r_edge <= r_edge + 1'b1;
        if (r_sck && !w_last_fall) begin
          r_shift <= r_shift << 1;
          r_mosi  <= r_shift[DATA_WIDTH-2];
        end
      end
    end
  end

  assign o_ready = w_ready;
  assign o_sck   = r_sck;
  assign o_mosi  = r_mosi;
  assign o_cs_n  = r_cs_n;
  assign o_dc    = r_dc;
  assign o_busy  = ~r_cs_n;
  assign o_done  = r_done;
endmodule
